icb_splt: RTL and testbench

- Single-master to SPLT_NUM-slave ICB address splitter.
- Sits directly downstream of the ICB arbiter: it takes the arbiter's merged command stream and routes each command to one slave by address-region decode.
- Routes slave responses back in order. Tracks outstanding transactions with a counter plus a current-target register, so no per-transaction FIFO is needed.

---
 rtl/icb_splt.sv | 163 ++++++++++++++++
 tb/tb_icb_splt.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_splt.sv
// Single-master to SPLT_NUM-slave ICB address splitter with in-order response return.
// Define SPLT_ERR_RSP_EN to route unmapped addresses to an internal error responder.
module icb_splt #(
  parameter int                     AW              = 32,
  parameter int                     DW              = 64,
  parameter int                     USR_W           = 1,
  parameter int                     SPLT_NUM        = 4,
  parameter int                     OUTS_DP         = 4,
  parameter logic [SPLT_NUM*AW-1:0] SPLT_BASE       = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [SPLT_NUM*AW-1:0] SPLT_MASK       = {4{32'hF000_0000}},
  parameter int                     ALLOW_0CYCL_RSP = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_icb_cmd_vld,
  output logic                      i_icb_cmd_rdy,
  input  logic                      i_icb_cmd_read,
  input  logic [AW-1:0]             i_icb_cmd_addr,
  input  logic [DW-1:0]             i_icb_cmd_wdata,
  input  logic [DW/8-1:0]           i_icb_cmd_wmask,
  input  logic [USR_W-1:0]          i_icb_cmd_usr,
  output logic                      i_icb_rsp_vld,
  input  logic                      i_icb_rsp_rdy,
  output logic                      i_icb_rsp_err,
  output logic [DW-1:0]             i_icb_rsp_rdata,
  output logic [USR_W-1:0]          i_icb_rsp_usr,
  output logic [SPLT_NUM-1:0]       o_bus_icb_cmd_vld,
  input  logic [SPLT_NUM-1:0]       o_bus_icb_cmd_rdy,
  output logic [SPLT_NUM-1:0]       o_bus_icb_cmd_read,
  output logic [SPLT_NUM*AW-1:0]    o_bus_icb_cmd_addr,
  output logic [SPLT_NUM*DW-1:0]    o_bus_icb_cmd_wdata,
  output logic [SPLT_NUM*DW/8-1:0]  o_bus_icb_cmd_wmask,
  output logic [SPLT_NUM*USR_W-1:0] o_bus_icb_cmd_usr,
  input  logic [SPLT_NUM-1:0]       o_bus_icb_rsp_vld,
  output logic [SPLT_NUM-1:0]       o_bus_icb_rsp_rdy,
  input  logic [SPLT_NUM-1:0]       o_bus_icb_rsp_err,
  input  logic [SPLT_NUM*DW-1:0]    o_bus_icb_rsp_rdata,
  input  logic [SPLT_NUM*USR_W-1:0] o_bus_icb_rsp_usr
);

  localparam int CW = $clog2(OUTS_DP + 1);
  localparam int NT = SPLT_NUM + 1;
  localparam logic [SPLT_NUM-1:0] ONE  = {{(SPLT_NUM-1){1'b0}}, 1'b1};
  localparam logic [SPLT_NUM-1:0] DFLT = {1'b1, {(SPLT_NUM-1){1'b0}}};

  logic [SPLT_NUM-1:0] hit;
  logic [SPLT_NUM-1:0] hit_low;
  logic                miss;
  logic [NT-1:0]       sel;
  logic [NT-1:0]       src;
  logic [NT-1:0]       cur_sel;
  logic [CW-1:0]       cnt;
  logic                allow;
  logic                tgt_rdy;
  logic                cmd_hsk;
  logic                rsp_hsk;
  logic                err_vld;
  logic                err_rdy;
  logic [USR_W-1:0]    err_rsp_usr;

  // Command fields go to every slave; only the vld is steered.
  assign o_bus_icb_cmd_read  = {SPLT_NUM{i_icb_cmd_read}};
  assign o_bus_icb_cmd_addr  = {SPLT_NUM{i_icb_cmd_addr}};
  assign o_bus_icb_cmd_wdata = {SPLT_NUM{i_icb_cmd_wdata}};
  assign o_bus_icb_cmd_wmask = {SPLT_NUM{i_icb_cmd_wmask}};
  assign o_bus_icb_cmd_usr   = {SPLT_NUM{i_icb_cmd_usr}};

  // Region decode; lowest hit index wins by isolating the lowest set bit.
  always_comb begin
    hit = {SPLT_NUM{1'b0}};
    for (int k = 0; k < SPLT_NUM; k++) begin
      hit[k] = ((i_icb_cmd_addr & SPLT_MASK[k*AW +: AW]) ==
                (SPLT_BASE[k*AW +: AW] & SPLT_MASK[k*AW +: AW]));
    end
    hit_low = hit & (~hit + ONE);
    miss    = ~|hit;
`ifdef SPLT_ERR_RSP_EN
    sel = {miss, hit_low};
`else
    sel = {1'b0, hit_low | ({SPLT_NUM{miss}} & DFLT)};
`endif
  end

  // Issue only to the target already in flight, so responses stay ordered.
  always_comb begin
    allow             = (cnt == {CW{1'b0}}) | ((cnt < CW'(OUTS_DP)) & (sel == cur_sel));
    tgt_rdy           = (|(sel[SPLT_NUM-1:0] & o_bus_icb_cmd_rdy)) | (sel[SPLT_NUM] & err_rdy);
    i_icb_cmd_rdy     = allow & tgt_rdy;
    o_bus_icb_cmd_vld = sel[SPLT_NUM-1:0] & {SPLT_NUM{i_icb_cmd_vld & allow}};
    cmd_hsk           = i_icb_cmd_vld & i_icb_cmd_rdy;
  end

  // Response source selection.
  always_comb begin
    if (cnt != {CW{1'b0}}) begin
      src = cur_sel;
    end else if ((ALLOW_0CYCL_RSP != 0) && cmd_hsk) begin
      src = sel;
    end else begin
      src = {NT{1'b0}};
    end
  end

  // Response mux back to the master.
  always_comb begin
    i_icb_rsp_vld   = src[SPLT_NUM] & err_vld;
    i_icb_rsp_err   = src[SPLT_NUM] & err_vld;
    i_icb_rsp_rdata = {DW{1'b0}};
    i_icb_rsp_usr   = {USR_W{src[SPLT_NUM]}} & err_rsp_usr;
    for (int k = 0; k < SPLT_NUM; k++) begin
      i_icb_rsp_vld   = i_icb_rsp_vld | (src[k] & o_bus_icb_rsp_vld[k]);
      i_icb_rsp_err   = i_icb_rsp_err | (src[k] & o_bus_icb_rsp_err[k]);
      i_icb_rsp_rdata = i_icb_rsp_rdata | ({DW{src[k]}} & o_bus_icb_rsp_rdata[k*DW +: DW]);
      i_icb_rsp_usr   = i_icb_rsp_usr | ({USR_W{src[k]}} & o_bus_icb_rsp_usr[k*USR_W +: USR_W]);
    end
    o_bus_icb_rsp_rdy = src[SPLT_NUM-1:0] & {SPLT_NUM{i_icb_rsp_rdy}};
    rsp_hsk           = i_icb_rsp_vld & i_icb_rsp_rdy;
  end

  // Outstanding counter and current target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= {CW{1'b0}};
      cur_sel <= {NT{1'b0}};
    end else begin
      case ({cmd_hsk, rsp_hsk})
        2'b10:   cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
        default: cnt <= cnt;
      endcase
      if (cmd_hsk) begin
        cur_sel <= sel;
      end
    end
  end

`ifdef SPLT_ERR_RSP_EN
  logic             err_pend;
  logic [USR_W-1:0] err_usr;

  // Internal error responder: one pending error at a time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend <= 1'b0;
      err_usr  <= {USR_W{1'b0}};
    end else if (cmd_hsk & sel[SPLT_NUM]) begin
      err_pend <= 1'b1;
      err_usr  <= i_icb_cmd_usr;
    end else if (rsp_hsk & src[SPLT_NUM]) begin
      err_pend <= 1'b0;
    end
  end

  assign err_vld     = err_pend;
  assign err_rdy     = ~err_pend;
  assign err_rsp_usr = err_usr;
`else
  assign err_vld     = 1'b0;
  assign err_rdy     = 1'b0;
  assign err_rsp_usr = {USR_W{1'b0}};
`endif

endmodule

// File: tb/tb_icb_splt.sv
// Self-checking bench for icb_splt: decode table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_icb_splt;
  localparam int N = 4, AW = 32, DW = 64, UW = 1, OD = 4;
  localparam logic [31:0] MASK = 32'hF000_0000;
  localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            cmd_vld, cmd_rdy, cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic [UW-1:0]   cmd_usr;
  logic            rsp_vld, rsp_rdy, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [UW-1:0]   rsp_usr;
  logic [N-1:0]    b_cmd_vld, s_cmd_rdy, b_cmd_read, b_rsp_rdy, s_rsp_vld, s_rsp_err;
  logic [N*AW-1:0] b_cmd_addr;
  logic [N*DW-1:0] b_cmd_wdata, s_rsp_rdata;
  logic [N*DW/8-1:0] b_cmd_wmask;
  logic [N*UW-1:0] b_cmd_usr, s_rsp_usr;

  int errors = 0;
  int checks = 0;

  icb_splt dut (
    .clk(clk), .rst(rst),
    .i_icb_cmd_vld(cmd_vld), .i_icb_cmd_rdy(cmd_rdy), .i_icb_cmd_read(cmd_read),
    .i_icb_cmd_addr(cmd_addr), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_cmd_usr(cmd_usr), .i_icb_rsp_vld(rsp_vld), .i_icb_rsp_rdy(rsp_rdy),
    .i_icb_rsp_err(rsp_err), .i_icb_rsp_rdata(rsp_rdata), .i_icb_rsp_usr(rsp_usr),
    .o_bus_icb_cmd_vld(b_cmd_vld), .o_bus_icb_cmd_rdy(s_cmd_rdy), .o_bus_icb_cmd_read(b_cmd_read),
    .o_bus_icb_cmd_addr(b_cmd_addr), .o_bus_icb_cmd_wdata(b_cmd_wdata),
    .o_bus_icb_cmd_wmask(b_cmd_wmask), .o_bus_icb_cmd_usr(b_cmd_usr),
    .o_bus_icb_rsp_vld(s_rsp_vld), .o_bus_icb_rsp_rdy(b_rsp_rdy), .o_bus_icb_rsp_err(s_rsp_err),
    .o_bus_icb_rsp_rdata(s_rsp_rdata), .o_bus_icb_rsp_usr(s_rsp_usr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    cmd_vld = 1'b0; cmd_read = 1'b0; cmd_addr = 32'h0; cmd_wdata = 64'h0; cmd_wmask = 8'h0;
    cmd_usr = 1'b0; rsp_rdy = 1'b0; s_cmd_rdy = 4'h0; s_rsp_vld = 4'h0; s_rsp_err = 4'h0;
    s_rsp_rdata = 256'h0; s_rsp_usr = 4'h0;
  endtask

  task automatic drv(input logic [31:0] a, input logic rd, input logic u);
    cmd_vld = 1'b1; cmd_addr = a; cmd_read = rd; cmd_usr = u;
  endtask

  // Target index from the region rules: lowest hit wins; a miss goes to the
  // error responder (index N) or to the default slave N-1.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < N; k++) begin
      if ((a & MASK) == (BASES[k] & MASK)) return k;
    end
`ifdef SPLT_ERR_RSP_EN
    return N;
`else
    return N - 1;
`endif
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  srdy;
    logic [3:0]  srvld;
    logic [3:0]  exp_vld;
    logic        exp_rdy;
    logic        exp_rvld;
  } vec_t;
  vec_t vt [6];

  int q [$];
  logic [UW-1:0] eu;

  initial begin
    vt[0] = '{32'h2000_0010, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0};
    vt[1] = '{32'h0000_1234, 4'b1111, 4'b0001, 4'b0001, 1'b1, 1'b1};
    vt[2] = '{32'h3FFF_FFFC, 4'b0111, 4'b1000, 4'b1000, 1'b0, 1'b0};
    vt[3] = '{32'h1ABC_0000, 4'b0010, 4'b0100, 4'b0010, 1'b1, 1'b0};
`ifdef SPLT_ERR_RSP_EN
    vt[4] = '{32'h5000_0000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0};
    vt[5] = '{32'hF000_0004, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
`else
    vt[4] = '{32'h5000_0000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1};
    vt[5] = '{32'hF000_0004, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0};
`endif

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    #1 chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_bus_vld", b_cmd_vld, 4'h0);
    drv(32'h3000_0000, 1'b1, 1'b0); s_cmd_rdy = 4'hF;
    #1 chk("rst_cmd_rdy", cmd_rdy, 1'b1);
    cmd_vld = 1'b0;

    // Decode table, applied and withdrawn before any clock edge.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv(vt[i].addr, 1'b1, 1'b0);
      s_cmd_rdy = vt[i].srdy; s_rsp_vld = vt[i].srvld; rsp_rdy = 1'b1;
      #1 chk($sformatf("tbl%0d_vld", i), b_cmd_vld, vt[i].exp_vld);
      chk($sformatf("tbl%0d_rdy", i), cmd_rdy, vt[i].exp_rdy);
      chk($sformatf("tbl%0d_rvld", i), rsp_vld, vt[i].exp_rvld);
      cmd_vld = 1'b0; s_rsp_vld = 4'h0;
    end

    // Read to slave 2 with a one-cycle-later response.
    @(negedge clk);
    drv(32'h2000_0010, 1'b1, 1'b0); s_cmd_rdy = 4'b0100; rsp_rdy = 1'b1;
    #1 chk("s1_vld", b_cmd_vld, 4'b0100);
    chk("s1_rdy", cmd_rdy, 1'b1);
    @(negedge clk);
    cmd_vld = 1'b0; s_rsp_vld = 4'b0100; s_rsp_rdata[2*DW +: DW] = 64'hAB; s_rsp_err = 4'h0;
    #1 chk("s1_rsp_vld", rsp_vld, 1'b1);
    chk("s1_rdata", rsp_rdata, 64'hAB);
    chk("s1_err", rsp_err, 1'b0);
    chk("s1_bus_rdy", b_rsp_rdy, 4'b0100);
    @(negedge clk);
    s_rsp_vld = 4'h0; drv(32'h0000_0000, 1'b1, 1'b0); s_cmd_rdy = 4'b0001;
    #1 chk("s1_cnt0", cmd_rdy, 1'b1);
    cmd_vld = 1'b0;

    // Outstanding limit with slave 1 holding responses.
    s_cmd_rdy = 4'b0010; s_rsp_vld = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(32'h1000_0000, 1'b0, 1'b0);
      #1 chk($sformatf("s2_acc%0d", i), cmd_rdy, 1'b1);
    end
    @(negedge clk);
    #1 chk("s2_5th_stall", cmd_rdy, 1'b0);
    chk("s2_5th_vld", b_cmd_vld, 4'h0);
    s_rsp_vld = 4'b0010;
    @(negedge clk);
    s_rsp_vld = 4'h0;
    #1 chk("s2_5th_acc", cmd_rdy, 1'b1);
    chk("s2_5th_bvld", b_cmd_vld, 4'b0010);
    @(negedge clk);
    cmd_vld = 1'b0; s_rsp_vld = 4'b0010;
    #1 chk("s2_drain_vld", rsp_vld, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 chk("s2_drained", rsp_vld, 1'b0);
    s_rsp_vld = 4'h0;

    // Different-target command waits for the outstanding response.
    @(negedge clk);
    drv(32'h0000_0040, 1'b1, 1'b0); s_cmd_rdy = 4'hF;
    #1 chk("s3_p0", cmd_rdy, 1'b1);
    @(negedge clk);
    drv(32'h3000_0000, 1'b1, 1'b0);
    #1 chk("s3_stall", cmd_rdy, 1'b0);
    chk("s3_stall_vld", b_cmd_vld, 4'h0);
    @(negedge clk);
    #1 chk("s3_stall2", cmd_rdy, 1'b0);
    s_rsp_vld = 4'b0001;
    #1 chk("s3_p0_rsp", rsp_vld, 1'b1);
    @(negedge clk);
    s_rsp_vld = 4'h0;
    #1 chk("s3_p3_vld", b_cmd_vld, 4'b1000);
    chk("s3_p3_rdy", cmd_rdy, 1'b1);
    @(negedge clk);
    cmd_vld = 1'b0; s_rsp_vld = 4'b1000;
    #1 chk("s3_p3_rsp", rsp_vld, 1'b1);
    @(negedge clk);
    s_rsp_vld = 4'h0;

    // Zero-cycle response.
    @(negedge clk);
    drv(32'h0000_0100, 1'b1, 1'b0); s_cmd_rdy = 4'b0001; s_rsp_vld = 4'b0001;
    s_rsp_rdata[0 +: DW] = 64'h55; rsp_rdy = 1'b1;
    #1 chk("s4_rsp_vld", rsp_vld, 1'b1);
    chk("s4_rdata", rsp_rdata, 64'h55);
    chk("s4_bus_rdy", b_rsp_rdy, 4'b0001);
    @(negedge clk);
    s_rsp_vld = 4'h0; drv(32'h2000_0000, 1'b1, 1'b0); s_cmd_rdy = 4'b0100;
    #1 chk("s4_cnt0", cmd_rdy, 1'b1);
    chk("s4_no_rsp", rsp_vld, 1'b0);
    cmd_vld = 1'b0;

`ifdef SPLT_ERR_RSP_EN
    // Error responder.
    @(negedge clk);
    drv(32'h5000_0000, 1'b1, 1'b1); s_cmd_rdy = 4'hF; rsp_rdy = 1'b0;
    #1 chk("s5_vld", b_cmd_vld, 4'h0);
    chk("s5_rdy", cmd_rdy, 1'b1);
    @(negedge clk);
    #1 chk("s5_2nd_stall", cmd_rdy, 1'b0);
    chk("s5_rsp_vld", rsp_vld, 1'b1);
    chk("s5_err", rsp_err, 1'b1);
    chk("s5_rdata", rsp_rdata, 64'h0);
    chk("s5_usr", rsp_usr, 1'b1);
    cmd_vld = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    drv(32'h0000_0000, 1'b1, 1'b0);
    #1 chk("s5_cleared", cmd_rdy, 1'b1);
    cmd_vld = 1'b0;
`endif

    // Asynchronous reset with three outstanding.
    s_cmd_rdy = 4'b0010; s_rsp_vld = 4'h0; rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(32'h1000_0000, 1'b0, 1'b0);
      #1 chk($sformatf("s6_acc%0d", i), cmd_rdy, 1'b1);
    end
    @(negedge clk);
    drv(32'h2000_0000, 1'b1, 1'b0); s_cmd_rdy = 4'b0110;
    #1 chk("s6_pre", cmd_rdy, 1'b0);
    #1 rst = 1'b1;
    s_rsp_vld = 4'b0010;
    #1 chk("s6_async", cmd_rdy, 1'b1);
    chk("s6_drop", rsp_vld, 1'b0);
    @(negedge clk);
    rst = 1'b0; s_rsp_vld = 4'h0;
    #1 chk("s6_after", cmd_rdy, 1'b1);
    cmd_vld = 1'b0;

    // Randomized traffic against the queue model.
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    eu = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int pick, t, src;
      bit allow_m, trdy, ep, hsk_c, hsk_r, exp_rv, exp_rdy;
      logic [3:0] nib;
      @(negedge clk);
      pick = $urandom_range(0, 5);
      nib = (pick < 4) ? 4'(pick) : ((pick == 4) ? 4'h5 : 4'hF);
      cmd_vld = ($urandom_range(0, 3) != 0);
      cmd_addr = {nib, 28'($urandom)};
      cmd_read = 1'($urandom); cmd_usr = 1'($urandom);
      cmd_wdata = {$urandom, $urandom}; cmd_wmask = 8'($urandom);
      s_cmd_rdy = 4'($urandom); s_rsp_vld = 4'($urandom & $urandom);
      s_rsp_err = 4'($urandom); s_rsp_usr = 4'($urandom);
      for (int k = 0; k < 8; k++) s_rsp_rdata[k*32 +: 32] = $urandom;
      rsp_rdy = ($urandom_range(0, 3) != 0);
      #1;
      t = decode(cmd_addr);
      ep = (q.size() > 0) && (q[0] == N);
      allow_m = (q.size() == 0) || ((q.size() < OD) && (t == q[0]));
      trdy = (t == N) ? !ep : s_cmd_rdy[t];
      exp_rdy = allow_m && trdy;
      hsk_c = cmd_vld && exp_rdy;
      chk("rnd_cmd_rdy", cmd_rdy, exp_rdy);
      chk("rnd_bus_vld", b_cmd_vld, (cmd_vld && allow_m && t < N) ? (4'b0001 << t) : 4'h0);
      src = (q.size() > 0) ? q[0] : (hsk_c ? t : -1);
      exp_rv = (src < 0) ? 1'b0 : ((src == N) ? (q.size() > 0) : s_rsp_vld[src]);
      chk("rnd_rsp_vld", rsp_vld, exp_rv);
      chk("rnd_bus_rdy", b_rsp_rdy, (src >= 0 && src < N && rsp_rdy) ? (4'b0001 << src) : 4'h0);
      if (exp_rv) begin
        chk("rnd_rdata", rsp_rdata, (src == N) ? 64'h0 : s_rsp_rdata[src*DW +: DW]);
        chk("rnd_err", rsp_err, (src == N) ? 1'b1 : s_rsp_err[src]);
        chk("rnd_usr", rsp_usr, (src == N) ? eu : s_rsp_usr[src]);
      end
      hsk_r = exp_rv && rsp_rdy;
      @(posedge clk);
      if (hsk_c) begin
        q.push_back(t);
        if (t == N) eu = cmd_usr;
      end
      if (hsk_r) void'(q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
